mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Multi-cycle load/store sequencer between the decode controller (MemRead, MemWrite, funct3) and a handshaked data-memory bus.
- Stalls the core until the bus acknowledges, then formats the data:
  - builds byte-lane enables and replicated write data for stores;
  - returns sign- or zero-extended read data for loads.
- Flags misaligned accesses, illegal access sizes and bus timeouts.

Parameters:
- TIMEOUT, 255, max cycles in BUSY without bus_ack before a fault; legal range 1..255.
- CNT_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- MemRead  in  1  load requested by the current instruction.
- MemWrite  in  1  store requested by the current instruction.
- funct3  in  3  [1:0] size: 00 byte, 01 half, 10 word, 11 illegal; [2]=1 zero-extend on load.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- stall  out  1  freeze PC and pipeline this cycle.
- rdata  out  32  extended load result; valid in DONE.
- fault  out  1  one-cycle pulse: misaligned, illegal size or timeout.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_be  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  bus completes the transfer this cycle.
- bus_rdata  in  32  read data, valid with bus_ack.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all registered outputs 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, fault); timeout counter 0.
  - Reset mid-transfer drops bus_req immediately; any late bus_ack is ignored.
- States:
  - IDLE:
    - (MemRead|MemWrite) and aligned, legal size -> BUSY; register bus_req=1, bus_we=MemWrite, address, be, wdata.
    - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=11 -> FAULT; no bus activity.
  - BUSY:
    - bus_ack=1 -> DONE: bus_req=0; rdata captured when a load.
    - Counter reaches TIMEOUT with no ack -> FAULT: bus_req=0.
    - Otherwise hold all bus outputs, counter+1.
  - DONE: one cycle, then -> IDLE. MemRead/MemWrite are ignored; they still belong to the finishing instruction.
  - FAULT: fault=1 for exactly this cycle, then -> IDLE.
- Counter: cleared on entering BUSY.
- stall (combinational):
  - 1 in BUSY.
  - 1 in IDLE when a legal, aligned request is present.
  - 0 in IDLE when the request is faulting; that instruction waits on FAULT.
  - 0 in DONE and FAULT; the core advances at the end of those cycles.
- MemRead and MemWrite both 1: treated as a store.
- Latency:
  - Request seen in IDLE at cycle 0; bus_req high from cycle 1.
  - Ack in cycle k -> DONE in k+1.
  - Minimum 3 cycles per access (ack in cycle 1).
- Byte lanes (o = addr[1:0]):
  - byte: bus_be = 1<<o; bus_wdata = {4{wdata[7:0]}}.
  - half: bus_be = o[1] ? 1100 : 0011; bus_wdata = {2{wdata[15:0]}}.
  - word: bus_be = 1111; bus_wdata = wdata.
  - Loads drive the same bus_be.
- Load extension:
  - Selected lane taken from bus_rdata.
  - Sign-extended when funct3[2]=0, zero-extended when 1.
  - Registered into rdata on ack; held until the next load completes.
- bus_addr/bus_be/bus_we/bus_wdata are stable while bus_req=1. The bus may ack in the first BUSY cycle.

Test Plan:
- LW, addr=0x100, ack after 3 BUSY cycles, bus_rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, stall high 4 cycles, DONE with rdata=0xDEADBEEF, stall 0.
- LB, addr=0x103, funct3=000, bus_rdata=0x80xxxxxx -> bus_be=1000, rdata=0xFFFFFF80. Same with funct3=100 (LBU) -> rdata=0x00000080.
- SB, addr=0x201, wdata=0x123456AB, ack in first BUSY cycle -> bus_we=1, bus_be=0010, bus_wdata=0xABABABAB, bus_addr=0x200, DONE next cycle.
- SW, addr=0x302 -> stall 0, FAULT: fault=1 for one cycle, bus_req never asserted. funct3=011 load -> same response.
- TIMEOUT=4, LW with bus_ack held 0 -> bus_req high 4 cycles, then FAULT pulse, bus_req 0, state IDLE.
- rst_n low during BUSY -> bus_req, stall (once inputs idle) and all outputs 0 asynchronously. An ack after reset release, with no request, causes no DONE.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between the decode controller and a handshaked
// data-memory bus: byte-lane formatting, load extension, misalign/size/timeout faults.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_wdata = {4{data[7:0]}};
            2'b01:   lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic zext,
                                                input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'b00:   load_extend = {{24{sh[7]  & ~zext}}, sh[7:0]};
            2'b01:   load_extend = {{16{sh[15] & ~zext}}, sh[15:0]};
            default: load_extend = raw;
        endcase
    endfunction

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       size_r, off_r;
    logic             zext_r;
    logic             req_s, bad_s, timeout_s;
    logic             stall_s;
    logic             bus_req_r, bus_we_r, fault_r;
    logic [31:0]      bus_addr_r, bus_wdata_r, rdata_r;
    logic [3:0]       bus_be_r;

    assign req_s     = MemRead | MemWrite;
    assign bad_s     = (funct3[1:0] == 2'b11) ||
                       ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign timeout_s = (cnt_r == CNT_LAST);

    // Next-state selection and the combinational stall.
    always_comb begin
        state_next_s = state_r;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (bad_s) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_BUSY;
                        stall_s      = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    state_next_s = ST_DONE;
                end else if (timeout_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            ST_FAULT: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bus request launch/hold, timeout counter, load capture and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
            fault_r     <= 1'b0;
            cnt_r       <= '0;
            size_r      <= 2'd0;
            off_r       <= 2'd0;
            zext_r      <= 1'b0;
        end else begin
            fault_r <= (state_next_s == ST_FAULT);
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_BUSY) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= MemWrite;
                        bus_addr_r  <= {addr[31:2], 2'b00};
                        bus_be_r    <= lane_be(funct3[1:0], addr[1:0]);
                        bus_wdata_r <= lane_wdata(funct3[1:0], wdata);
                        size_r      <= funct3[1:0];
                        off_r       <= addr[1:0];
                        zext_r      <= funct3[2];
                        cnt_r       <= '0;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        bus_req_r <= 1'b0;
                        if (!bus_we_r) begin
                            rdata_r <= load_extend(size_r, zext_r, off_r, bus_rdata);
                        end
                    end else if (timeout_s) begin
                        bus_req_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign rdata     = rdata_r;
    assign fault     = fault_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench: the driver pushes expected bus launches and completions from a
// behavioural model; a negedge monitor pops and compares whenever the DUT responds.
module tb_mem_access_sequencer;
    localparam int TMO = 4;

    logic        clk, rst_n, MemRead, MemWrite, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stall, fault, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    mem_access_sequencer #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
    typedef struct { bit is_fault; int stall_n; int req_n; logic [31:0] rdata; } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
        int sz = int'(f3[1:0]);
        return (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [2:0] f3,
                                               input logic [1:0] o);
        int bits;
        logic [31:0] v, mask;
        bits = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
        v = raw >> (8 * int'(o));
        if (bits == 32) return raw;
        mask = (32'd1 << bits) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // d = number of BUSY cycles before the ack cycle; d >= TMO means no ack at all
    task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int d,
                          input logic [31:0] rdv);
        bit bad;
        bus_t b;
        res_t r;
        int o;
        bad = model_bad(f3, a);
        o = int'(a[1:0]);
        if (bad) begin
            r = '{1'b1, 0, 0, last_rdata};
        end else begin
            b.we = wr;
            b.addr = a & 32'hFFFF_FFFC;
            b.be = (f3[1:0] == 2'b00) ? 4'(1 << o) : (f3[1:0] == 2'b01) ? ((o >= 2) ? 4'hC : 4'h3) : 4'hF;
            b.wdata = (f3[1:0] == 2'b00) ? 32'(wd[7:0]) * 32'h0101_0101 :
                      (f3[1:0] == 2'b01) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
            bus_q.push_back(b);
            if (d < TMO) begin
                if (!wr) last_rdata = model_load(rdv, f3, a[1:0]);
                r = '{1'b0, d + 2, d + 1, last_rdata};
            end else begin
                r = '{1'b1, TMO + 1, TMO, last_rdata};
            end
        end
        res_q.push_back(r);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
        @(posedge clk); #1;
        if (!bad) begin
            for (int c = 1; c <= TMO; c++) begin
                if (c == d + 1) begin bus_ack = 1'b1; bus_rdata = rdv; end
                else begin bus_ack = 1'b0; bus_rdata = $urandom; end
                @(posedge clk); #1;
                if (c == d + 1) break;
            end
            bus_ack = 1'b0;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops expectations on bus launch and on each completion/fault.
    initial begin
        logic prev_req;
        int st_cnt, rq_cnt;
        bus_t cur, eb;
        res_t er;
        prev_req = 1'b0; st_cnt = 0; rq_cnt = 0;
        cur = '{1'b0, 32'd0, 4'd0, 32'd0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0; st_cnt = 0; rq_cnt = 0;
            end else begin
                if (stall) st_cnt++;
                if (bus_req) rq_cnt++;
                if (bus_req && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 32'(bus_req), 32'd0);
                    end else begin
                        eb = bus_q.pop_front();
                        check("bus_we", 32'(bus_we), 32'(eb.we));
                        check("bus_addr", bus_addr, eb.addr);
                        check("bus_be", 32'(bus_be), 32'(eb.be));
                        if (eb.we) check("bus_wdata", bus_wdata, eb.wdata);
                    end
                    cur = '{bus_we, bus_addr, bus_be, bus_wdata};
                end else if (bus_req) begin
                    check("bus_stable", {bus_addr[31:2], bus_we, bus_be != cur.be},
                          {cur.addr[31:2], cur.we, 1'b0});
                end
                if (fault || (prev_req && !bus_req)) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_completion", 32'(fault), 32'd2);
                    end else begin
                        er = res_q.pop_front();
                        check("fault_kind", 32'(fault), 32'(er.is_fault));
                        check("stall_cycles", 32'(st_cnt), 32'(er.stall_n));
                        check("req_cycles", 32'(rq_cnt), 32'(er.req_n));
                        check("rdata", rdata, er.rdata);
                    end
                    st_cnt = 0; rq_cnt = 0;
                end
                prev_req = bus_req;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3;
        logic [31:0] a;
        logic rd, wr;
        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        #1;
        check("reset_bus_req", 32'(bus_req), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_bus_addr", bus_addr, 32'd0);
        check("reset_bus_be", 32'(bus_be), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 2, 32'hDEAD_BEEF);   // LW
        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h8012_3456);   // LB
        do_txn(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 0, 32'h8012_3456);   // LBU
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 0, 32'd0);   // SB
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0302, 32'h5555_AAAA, 0, 32'd0);   // misaligned SW
        do_txn(1'b1, 1'b0, 3'b011, 32'h0000_0400, 32'd0, 0, 32'd0);           // illegal size
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0, TMO, 32'd0);         // timeout
        do_txn(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 3, 32'h8001_7FFF);   // LH upper lane
        do_txn(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 3, 32'h8001_7FFF);   // LHU
        do_txn(1'b1, 1'b1, 3'b001, 32'h0000_0602, 32'hCAFE_F00D, 1, 32'd0);   // both -> store

        // reset while BUSY
        bus_q.push_back('{1'b0, 32'h0000_0700, 4'hF, 32'd0});
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_0700; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; MemRead = 1'b0;
        #1;
        check("midreset_bus_req", 32'(bus_req), 32'd0);
        check("midreset_stall", 32'(stall), 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_bus_be", 32'(bus_be), 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 bus_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_rdata", rdata, 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        check("late_ack_bus_req", 32'(bus_req), 32'd0);
        check("late_ack_fault", 32'(fault), 32'd0);

        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
            do_txn(rd, wr, f3, a, $urandom, $urandom_range(0, TMO), $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
